// File: rtl/clock_gate_ctrl_if.sv
// clock_gate_ctrl_if: request/activity inputs and gated clock/status outputs of the clock gate controller
interface clock_gate_ctrl_if #(
    parameter int NCH    = 4,
    parameter int IDLE_W = 4
);
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    busy;
    logic [IDLE_W-1:0] idle_thr;
    logic [NCH-1:0]    gclk;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    on_sts;
    modport master (output req, busy, idle_thr, input gclk, ack, on_sts);
    modport slave  (input req, busy, idle_thr, output gclk, ack, on_sts);
endinterface

// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: per-channel request/idle clock gating with glitch-free latch gates; CLOCK_GATE_CTRL_TEST_EN adds test_en to force all gates open
module clock_gate_ctrl #(
    parameter int NCH      = 4,
    parameter int IDLE_W   = 4,
    parameter int WAKE_CYC = 2
) (
    input logic clk,
    input logic rst,
`ifdef CLOCK_GATE_CTRL_TEST_EN
    input logic test_en,
`endif
    clock_gate_ctrl_if.slave bus
);
    typedef enum logic [1:0] {OFF, WAKE, ON, IDLE} st_t;
    logic [NCH-1:0] en;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] gv;
    logic           te;
`ifdef CLOCK_GATE_CTRL_TEST_EN
    assign te = test_en;
`else
    assign te = 1'b0;
`endif
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        st_t               st, nx;
        logic [3:0]        wc, wc_n;
        logic [IDLE_W-1:0] ic, ic_n;
        logic [IDLE_W:0]   ic_p1;
        logic              len;
        logic              quiet;
        assign quiet = !bus.req[i] && !bus.busy[i];
        assign ic_p1 = {1'b0, ic} + {{IDLE_W{1'b0}}, 1'b1};
        // next state: wake countdown, idle countdown against the live threshold, request always wins
        always_comb begin
            nx   = st;
            wc_n = wc;
            ic_n = ic;
            case (st)
                OFF: if (bus.req[i]) begin
                    nx   = WAKE;
                    wc_n = '0;
                end
                WAKE: if (wc == 4'(WAKE_CYC - 1)) nx = ON;
                      else wc_n = wc + 4'd1;
                ON: if (quiet) begin
                    nx   = (bus.idle_thr == '0) ? OFF : IDLE;
                    ic_n = '0;
                end
                IDLE: if (!quiet) begin
                    nx   = ON;
                    ic_n = '0;
                end else if (ic_p1 >= {1'b0, bus.idle_thr}) begin
                    nx   = OFF;
                    ic_n = '0;
                end else ic_n = ic_p1[IDLE_W-1:0];
            endcase
        end
        // channel state and counters
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st <= OFF;
                wc <= '0;
                ic <= '0;
            end else begin
                st <= nx;
                wc <= wc_n;
                ic <= ic_n;
            end
        end
        assign en[i]  = st != OFF;
        assign ack[i] = (st == ON) || (st == IDLE);
        // enable latch, transparent only while clk is low so gclk never sees a partial high phase
        always_latch begin
            if (rst) len <= 1'b0;
            else if (!clk) len <= en[i] | te;
        end
        assign gv[i] = clk & len;
    end
    assign bus.gclk   = gv;
    assign bus.ack    = ack;
    assign bus.on_sts = en;
endmodule

// File: doc/clock_gate_ctrl.md
CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of independent gated clock channels (1..16).
REQ-002 Parameter IDLE_W, default 4: width of the idle countdown threshold.
REQ-003 Parameter WAKE_CYC, default 2: cycles from clock-on to ack (1..15).
REQ-004 clk  input  1  free-running source clock; all state on posedge clk.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 req  input  NCH  per-channel clock request; level, held until ack or withdrawn.
REQ-007 busy  input  NCH  per-channel activity flag from the clocked domain; blocks idle gating.
REQ-008 idle_thr  input  IDLE_W  idle cycles before gating off; shared by all channels; sampled each cycle.
REQ-009 gclk  output  NCH  per-channel gated clock.
REQ-010 ack  output  NCH  per-channel clock-stable acknowledge.
REQ-011 on_sts  output  NCH  per-channel registered enable, high while the channel's clock runs.

Function
REQ-012 Each channel SHALL run an independent FSM with states OFF, WAKE, ON and IDLE; channels SHALL NOT interact.
REQ-013 OFF: en=0, ack=0; req=1 at a posedge -> WAKE.
REQ-014 WAKE: en=1; wake counter counts WAKE_CYC posedges, then -> ON; ack rises on the cycle of entry to ON.
REQ-015 ON: en=1, ack=1; req=0 and busy=0 -> IDLE with idle counter=0.
REQ-016 IDLE: en=1, ack=1; counter increments each posedge with req=0 and busy=0; req=1 or busy=1 -> ON, counter cleared.
REQ-017 IDLE: counter reaching idle_thr -> OFF; en and ack fall on the same posedge.
REQ-018 idle_thr=0: ON with req=0 and busy=0 -> OFF directly on the next posedge.
REQ-019 idle_thr changed during IDLE: compare against the new value; counter already >= idle_thr -> OFF next posedge.
REQ-020 req withdrawn during WAKE: wake completes, then ON, then normal idle evaluation; no abort.
REQ-021 req=1 in the same cycle the IDLE counter hits idle_thr: req wins, channel stays ON.
REQ-022 gclk[i] SHALL be glitch-free: en[i] captured by a level latch transparent while clk is low, gclk[i] = clk AND latched enable.
REQ-023 gclk[i] SHALL rise only on a full high phase of clk; first gated edge is the clk rise after the posedge that sets en.
REQ-024 on_sts[i] SHALL equal registered en[i].

Reset
REQ-025 rst=1 SHALL force, asynchronously: all FSMs to OFF, counters 0, en=0, latched enables 0, gclk=0, ack=0, on_sts=0.
REQ-026 Reset asserted mid-WAKE or mid-ON SHALL cut gclk low without a runt pulse longer than the current clk high phase.
REQ-027 After rst deassertion, channels SHALL stay OFF until req is seen at a posedge.

Configuration
REQ-028 Macro CLOCK_GATE_CTRL_TEST_EN: when defined, input test_en (1 bit) is added; test_en=1 forces every latched enable to 1 (all gclk run, FSMs and ack unaffected).
REQ-029 Without CLOCK_GATE_CTRL_TEST_EN: no test_en port; gating governed solely by the FSMs.

Verification
REQ-030 Reset, then req[0]=1 with WAKE_CYC=2 -> on_sts[0]=1 at the next posedge, ack[0]=1 two posedges later, gclk[0] toggling from first clk rise after en.
REQ-031 Channel 1 ON, idle_thr=3, req and busy low -> gclk[1] stops and ack[1]=0 after exactly 3 idle cycles; other channels unchanged.
REQ-032 Channel 2 IDLE at count 2 of 3, busy[2] pulsed 1 cycle -> counter restarts, OFF 3 cycles after busy drops.
REQ-033 idle_thr=0, req[3] dropped with busy[3]=0 -> ack[3]=0 and gclk[3] low one posedge later.
REQ-034 rst asserted mid-clk-high with all channels ON -> all gclk, ack, on_sts 0 immediately; no gclk edge until new req.
REQ-035 With CLOCK_GATE_CTRL_TEST_EN, test_en=1 and all req=0 -> all gclk toggle, ack all 0; test_en=0 -> gclk stop glitch-free.
